// File: rtl/digit_shift_buffer_pkg.sv
// digit_shift_buffer_pkg
//   Shared definitions for the display digit shift buffer and its
//   UART-side neighbours: command codes carried with each strobe, FSM
//   encodings and a width helper for the settle timer.
//   Optional feature macro used by the top: DIGIT_SHIFT_PEND_EN.
package digit_shift_buffer_pkg;

  localparam logic [1:0] CMD_PUSH = 2'b00;
  localparam logic [1:0] CMD_BKSP = 2'b01;
  localparam logic [1:0] CMD_CLR  = 2'b10;
  localparam logic [1:0] CMD_NOP  = 2'b11;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_SETTLE = 1'b1;

  // Width of a down-counter that must hold values 0..n-1; never below 1 bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_shift_buffer_strobe_toggle_detect.sv
// strobe_toggle_detect
//   Turns a toggle-style strobe into a one-clock event. The strobe is
//   registered once (strb_q) and compared against the last acknowledged
//   level (prev_q). Asserting ack_i copies strb_q into prev_q, so an
//   acknowledged event lasts exactly one clock.
// Ports
//   clk       in   clock
//   rst       in   synchronous reset, active-low
//   strobe_i  in   toggle strobe from the source domain
//   ack_i     in   consume the current event
//   event_o   out  level change seen and not yet acknowledged
module strobe_toggle_detect (
  input  logic clk,
  input  logic rst,
  input  logic strobe_i,
  input  logic ack_i,
  output logic event_o
);

  logic strb_q;
  logic prev_q;
  logic prev_d;

  assign event_o = (strb_q != prev_q);
  assign prev_d  = ack_i ? strb_q : prev_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      strb_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      strb_q <= strobe_i;
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/digit_shift_buffer.sv
// digit_shift_buffer
//   Holds NUM_DIGITS display digits fed from the UART receiver. Every
//   level change of in_strobe is one command (push / backspace / clear /
//   no-op). After an event the block waits SETTLE_CYCLES clocks, then
//   samples in_data/in_cmd and applies the command on that edge.
//   Events arriving while busy are dropped and flagged in the sticky
//   'lost' bit, unless DIGIT_SHIFT_PEND_EN is defined, in which case one
//   event is held in a pending bit and only a second one is lost.
// Ports
//   clk          in   clock
//   rst          in   synchronous reset, active-low
//   in_data      in   digit value for push
//   in_cmd       in   00 push, 01 backspace, 10 clear, 11 no-op
//   in_strobe    in   toggle strobe
//   digits_flat  out  digit i at [i*DIGIT_W +: DIGIT_W], digit 0 newest
//   digit_count  out  valid digits held, saturates at NUM_DIGITS
//   busy         out  FSM not idle
//   lost         out  sticky dropped-strobe flag, cleared by clear
//
// state     | meaning
// ST_IDLE   | waiting for a strobe event (or a pending one)
// ST_SETTLE | counting down; command applied when the timer reaches 0
module digit_shift_buffer
  import digit_shift_buffer_pkg::*;
#(
  parameter int unsigned            NUM_DIGITS    = 4,
  parameter int unsigned            DIGIT_W       = 4,
  parameter int unsigned            SETTLE_CYCLES = 2,
  parameter logic [DIGIT_W-1:0]     BLANK_CODE    = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DIGIT_W-1:0]                in_data,
  input  logic [1:0]                        in_cmd,
  input  logic                              in_strobe,
  output logic [NUM_DIGITS*DIGIT_W-1:0]     digits_flat,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
  output logic                              busy,
  output logic                              lost
);

  localparam int unsigned CW    = $clog2(NUM_DIGITS + 1);
  localparam int unsigned TW    = cnt_width(SETTLE_CYCLES);
  localparam logic [CW-1:0] COUNT_MAX  = CW'(NUM_DIGITS);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(SETTLE_CYCLES - 1);

  logic               evt;
  logic [0:0]         state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [CW-1:0]      count_q, count_d;
  logic               lost_q,  lost_d;
  logic [DIGIT_W-1:0] digit_q [NUM_DIGITS];
  logic [DIGIT_W-1:0] digit_d [NUM_DIGITS];
  logic [DIGIT_W-1:0] push_v  [NUM_DIGITS];
  logic [DIGIT_W-1:0] bksp_v  [NUM_DIGITS];
  logic               apply;
  logic               busy_evt;
`ifdef DIGIT_SHIFT_PEND_EN
  logic               pending_q, pending_d;
`endif

  // Every event is acknowledged immediately: prev follows strb_q whether
  // the event starts a command, becomes pending or is lost.
  strobe_toggle_detect u_detect (
    .clk      (clk),
    .rst      (rst),
    .strobe_i (in_strobe),
    .ack_i    (evt),
    .event_o  (evt)
  );

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
    if (gi == 0) begin : g_head
      assign push_v[gi] = in_data;
    end else begin : g_body
      assign push_v[gi] = digit_q[gi-1];
    end
    if (gi == NUM_DIGITS - 1) begin : g_tail
      assign bksp_v[gi] = BLANK_CODE;
    end else begin : g_rest
      assign bksp_v[gi] = digit_q[gi+1];
    end
    assign digits_flat[gi*DIGIT_W +: DIGIT_W] = digit_q[gi];
  end

  assign apply    = (state_q == ST_SETTLE) && (timer_q == '0);
  assign busy_evt = evt && (state_q == ST_SETTLE);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    count_d = count_q;
    lost_d  = lost_q;
    digit_d = digit_q;
`ifdef DIGIT_SHIFT_PEND_EN
    pending_d = pending_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (evt) begin
          state_d = ST_SETTLE;
          timer_d = TIMER_LOAD;
        end
      end
      default: begin
        if (!apply) begin
          timer_d = timer_q - TW'(1);
        end else begin
          case (in_cmd)
            CMD_PUSH: begin
              digit_d = push_v;
              count_d = (count_q == COUNT_MAX) ? COUNT_MAX : count_q + CW'(1);
            end
            CMD_BKSP: begin
              if (count_q != '0) begin
                digit_d = bksp_v;
                count_d = count_q - CW'(1);
              end
            end
            CMD_CLR: begin
              for (int i = 0; i < NUM_DIGITS; i++) digit_d[i] = BLANK_CODE;
              count_d = '0;
              lost_d  = 1'b0;
            end
            default: ;
          endcase
          state_d = ST_IDLE;
`ifdef DIGIT_SHIFT_PEND_EN
          if (pending_q) begin
            state_d   = ST_SETTLE;
            timer_d   = TIMER_LOAD;
            pending_d = 1'b0;
          end
`endif
        end
      end
    endcase

    // A drop on the same edge as a clear still leaves lost set: that
    // strobe happened after the clear was issued.
`ifdef DIGIT_SHIFT_PEND_EN
    if (busy_evt) begin
      if (pending_q) begin
        lost_d = 1'b1;
      end else if (apply) begin
        // Slot frees on this very edge: start the new command directly.
        state_d = ST_SETTLE;
        timer_d = TIMER_LOAD;
      end else begin
        pending_d = 1'b1;
      end
    end
`else
    if (busy_evt) lost_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      count_q <= '0;
      lost_q  <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= BLANK_CODE;
`ifdef DIGIT_SHIFT_PEND_EN
      pending_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      count_q <= count_d;
      lost_q  <= lost_d;
      digit_q <= digit_d;
`ifdef DIGIT_SHIFT_PEND_EN
      pending_q <= pending_d;
`endif
    end
  end

  assign digit_count = count_q;
  assign busy        = (state_q == ST_SETTLE);
  assign lost        = lost_q;

endmodule

// File: tb/tb_digit_shift_buffer.sv
// tb_digit_shift_buffer
//   Directed bench for digit_shift_buffer at default parameters. Inputs
//   are driven and outputs sampled on the falling edge. Expectations for
//   back-to-back strobes follow DIGIT_SHIFT_PEND_EN.
module tb_digit_shift_buffer;
  import digit_shift_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_data;
  logic [1:0]  in_cmd;
  logic        in_strobe;
  logic [15:0] digits_flat;
  logic [2:0]  digit_count;
  logic        busy;
  logic        lost;

  logic        strb_lvl;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  digit_shift_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_cmd      (in_cmd),
    .in_strobe   (in_strobe),
    .digits_flat (digits_flat),
    .digit_count (digit_count),
    .busy        (busy),
    .lost        (lost)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic toggle();
    strb_lvl  = ~strb_lvl;
    in_strobe = strb_lvl;
  endtask

  // Issue one command and wait well past its apply edge.
  task automatic issue(input logic [1:0] cmd, input logic [3:0] data);
    in_cmd  = cmd;
    in_data = data;
    toggle();
    tick(6);
  endtask

  task automatic chk_state(input string tag, input logic [15:0] flat, input logic [2:0] cnt);
    chk({tag, "_flat"},  32'(digits_flat), 32'(flat));
    chk({tag, "_count"}, 32'(digit_count), 32'(cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    rst       = 1'b0;
    in_data   = 4'h0;
    in_cmd    = CMD_NOP;
    strb_lvl  = 1'b0;
    in_strobe = 1'b0;
    tick(2);
    chk_state("reset", 16'h0000, 3'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_lost", 32'(lost), 32'd0);
    rst = 1'b1;
    tick(2);

    issue(CMD_PUSH, 4'h1);  chk_state("push1", 16'h0001, 3'd1);
    issue(CMD_PUSH, 4'h2);  chk_state("push2", 16'h0012, 3'd2);
    issue(CMD_PUSH, 4'h3);  chk_state("push3", 16'h0123, 3'd3);
    issue(CMD_PUSH, 4'h4);  chk_state("push4", 16'h1234, 3'd4);
    issue(CMD_PUSH, 4'h5);  chk_state("push5_sat", 16'h2345, 3'd4);

    issue(CMD_BKSP, 4'hF);  chk_state("bksp1", 16'h0234, 3'd3);
    issue(CMD_BKSP, 4'hF);  chk_state("bksp2", 16'h0023, 3'd2);
    issue(CMD_BKSP, 4'hF);  chk_state("bksp3", 16'h0002, 3'd1);
    issue(CMD_BKSP, 4'hF);  chk_state("bksp4", 16'h0000, 3'd0);
    issue(CMD_BKSP, 4'hF);  chk_state("bksp_empty", 16'h0000, 3'd0);

    issue(CMD_PUSH, 4'hA);
    issue(CMD_PUSH, 4'hB);  chk_state("pushAB", 16'h00AB, 3'd2);
    issue(CMD_NOP, 4'hF);   chk_state("nop", 16'h00AB, 3'd2);
    chk("nop_lost", 32'(lost), 32'd0);

    // Three no-op strobes one clock apart: lost in either build.
    in_cmd = CMD_NOP;
    toggle(); tick(1);
    toggle(); tick(1);
    toggle(); tick(8);
    chk("burst_lost", 32'(lost), 32'd1);
    chk_state("burst", 16'h00AB, 3'd2);
    chk("burst_idle", 32'(busy), 32'd0);

    issue(CMD_CLR, 4'h0);   chk_state("clear", 16'h0000, 3'd0);
    chk("clear_lost", 32'(lost), 32'd0);

    // Latency: data valid only for the apply edge (third edge after sampling).
    in_cmd  = CMD_PUSH;
    in_data = 4'hE;
    toggle();
    tick(2);
    chk("lat_busy", 32'(busy), 32'd1);
    tick(1);
    chk("lat_before", 32'(digits_flat), 32'h0000);
    in_data = 4'h7;
    tick(1);
    chk("lat_at", 32'(digits_flat), 32'h0007);
    in_data = 4'hE;
    tick(3);
    chk_state("lat_after", 16'h0007, 3'd1);
    chk("lat_idle", 32'(busy), 32'd0);

    // Reset in the middle of the settle window abandons the push.
    in_cmd  = CMD_PUSH;
    in_data = 4'h7;
    toggle();
    tick(2);
    rst       = 1'b0;
    strb_lvl  = 1'b0;
    in_strobe = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(6);
    chk_state("rst_mid", 16'h0000, 3'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);

    // Two pushes two clocks apart.
    in_cmd  = CMD_PUSH;
    in_data = 4'h8;
    toggle();
    tick(2);
    toggle();
    tick(2);
    in_data = 4'h9;
    tick(6);
`ifdef DIGIT_SHIFT_PEND_EN
    chk_state("pair", 16'h0089, 3'd2);
    chk("pair_lost", 32'(lost), 32'd0);
`else
    chk_state("pair", 16'h0008, 3'd1);
    chk("pair_lost", 32'(lost), 32'd1);
`endif
    chk("pair_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
